// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide; fixed 34-cycle latency from Start to Done.
module mips_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic             i_hi_write,
  input  logic             i_lo_write,
  input  logic [WIDTH-1:0] i_move_data,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_div_by_zero,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_FIX} state_t;

  state_t               r_state;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_m;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_dbz;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  function automatic logic [WIDTH-1:0] f_neg(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_neg2(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  logic               w_signed;
  logic               w_is_div;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_top;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod;
  logic               w_dbz;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_signed = ~r_op[0];
  assign w_is_div = r_op[1];
  assign w_sa     = w_signed & r_a[WIDTH-1];
  assign w_sb     = w_signed & r_b[WIDTH-1];
  assign w_abs_a  = f_neg(r_a, w_sa);
  assign w_abs_b  = f_neg(r_b, w_sb);

  // Multiply step: acc = {partial product, remaining multiplier bits}, shifted right.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Divide step: acc = {remainder, dividend/quotient}; MSB of the 33-bit difference is the borrow.
  assign w_div_top  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff = w_div_top - {1'b0, r_m};
  assign w_div_ge   = ~w_div_diff[WIDTH];
  assign w_div_next = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_top[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_div_ge};

  assign w_prod = f_neg2(r_acc, r_neg_q);
  assign w_dbz  = w_is_div && (r_b == '0);

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (w_dbz) begin
      w_res_hi = r_a;
      w_res_lo = '1;
    end else if (w_is_div) begin
      w_res_hi = f_neg(r_acc[2*WIDTH-1:WIDTH], r_neg_r);
      w_res_lo = f_neg(r_acc[WIDTH-1:0], r_neg_q);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_hi_write) r_hi <= i_move_data;
          if (i_lo_write) r_lo <= i_move_data;
          if (i_start) begin
            r_op    <= i_op;
            r_a     <= i_operand_a;
            r_b     <= i_operand_b;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_acc   <= w_is_div ? {{WIDTH{1'b0}}, w_abs_a} : {{WIDTH{1'b0}}, w_abs_b};
          r_m     <= w_is_div ? w_abs_b : w_abs_a;
          r_neg_q <= w_sa ^ w_sb;
          r_neg_r <= w_sa;
          r_cnt   <= '0;
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_acc <= w_is_div ? w_div_next : w_mul_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(WIDTH-1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_res_hi;
          r_lo    <= w_res_lo;
          r_done  <= 1'b1;
          r_dbz   <= w_dbz;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_div_by_zero = r_dbz;
  assign o_hi          = r_hi;
  assign o_lo          = r_lo;

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed and random ops against a plain-arithmetic model.
module tb_mips_muldiv;
  logic        clk = 1'b0;
  logic        rst, start, hi_write, lo_write;
  logic [1:0]  op;
  logic [31:0] a, b, md;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  mips_muldiv #(.WIDTH(32), .CNT_W(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
    .i_operand_a(a), .i_operand_b(b), .i_hi_write(hi_write), .i_lo_write(lo_write),
    .i_move_data(md), .o_busy(busy), .o_done(done), .o_div_by_zero(dbz),
    .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // MIPS semantics expressed with native 64-bit arithmetic.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el, output logic ed);
    longint      p, q, r;
    logic [63:0] u;
    ed = 1'b0;
    eh = '0;
    el = '0;
    case (o)
      2'd0: begin
        p  = longint'($signed(x)) * longint'($signed(y));
        eh = p[63:32];
        el = p[31:0];
      end
      2'd1: begin
        u  = {32'b0, x} * {32'b0, y};
        eh = u[63:32];
        el = u[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          eh = x;
          el = 32'hFFFF_FFFF;
          ed = 1'b1;
        end else if (o == 2'd2) begin
          q  = longint'($signed(x)) / longint'($signed(y));
          r  = longint'($signed(x)) % longint'($signed(y));
          eh = r[31:0];
          el = q[31:0];
        end else begin
          el = x / y;
          eh = x % y;
        end
      end
    endcase
  endfunction

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 60) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  // now=1 asserts Start in the current cycle (used for back-to-back issue on the Done cycle).
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit now);
    logic [31:0] eh, el;
    logic        ed;
    int          lat, bcnt;
    model(o, x, y, eh, el, ed);
    if (!now) @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom_range(3));
    chk({tag, " done_low_after_start"}, 64'(done), 64'(0));
    chk({tag, " dbz_low_after_start"}, 64'(dbz), 64'(0));
    wait_done(lat, bcnt);
    chk({tag, " latency"}, 64'(lat), 64'(34));
    chk({tag, " busy_cycles"}, 64'(bcnt), 64'(34));
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
    chk({tag, " dbz"}, 64'(dbz), 64'(ed));
  endtask

  initial begin : main
    int          lat, bcnt, dcnt;
    logic [31:0] prev_hi, prev_lo, ra, rb;
    logic [1:0]  ro;

    rst = 1'b0; start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
    op = '0; a = '0; b = '0; md = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset dbz", 64'(dbz), 64'(0));
    chk("reset hi", 64'(hi), 64'(0));
    chk("reset lo", 64'(lo), 64'(0));
    rst = 1'b0;

    run_op("mult_7_m3", 2'd0, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
    chk("mult_7_m3 hi const", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_7_m3 lo const", 64'(lo), 64'hFFFF_FFEB);
    run_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("multu_max hi const", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_max lo const", 64'(lo), 64'h0000_0001);
    run_op("mult_m1_m1", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("mult_m1_m1 hi const", 64'(hi), 64'h0);
    run_op("div_m7_2", 2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    chk("div_m7_2 lo const", 64'(lo), 64'hFFFF_FFFD);
    chk("div_m7_2 hi const", 64'(hi), 64'hFFFF_FFFF);
    run_op("divu_100_7", 2'd3, 32'd100, 32'd7, 1'b0);
    chk("divu_100_7 lo const", 64'(lo), 64'd14);
    chk("divu_100_7 hi const", 64'(hi), 64'd2);
    run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_ovf lo const", 64'(lo), 64'h8000_0000);
    run_op("divu_by0", 2'd3, 32'h0000_0064, 32'h0, 1'b0);
    chk("divu_by0 done_with_dbz", 64'(done), 64'(1));
    run_op("b2b_multu", 2'd1, 32'd6, 32'd7, 1'b1);
    run_op("div_by0", 2'd2, 32'h8000_0001, 32'h0, 1'b0);

    // Start re-pulsed and HiWrite asserted while busy must both be ignored.
    prev_hi = hi;
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin
      if (lat == 9)  begin start = 1'b1; op = 2'd2; a = 32'd100; b = 32'd3; end
      if (lat == 10) start = 1'b0;
      if (lat == 11) begin hi_write = 1'b1; md = 32'h1234_5678; end
      if (lat == 12) hi_write = 1'b0;
      if (lat == 13) chk("busy_mthi_ignored", 64'(hi), 64'(prev_hi));
      @(negedge clk);
      lat++;
    end
    chk("preempt latency", 64'(lat), 64'(34));
    chk("preempt hi", 64'(hi), 64'h0);
    chk("preempt lo", 64'(lo), 64'd15);

    hi_write = 1'b1; md = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_write = 1'b0;
    chk("mthi hi", 64'(hi), 64'hDEAD_BEEF);
    chk("mthi lo_kept", 64'(lo), 64'd15);
    lo_write = 1'b1; md = 32'h0BAD_F00D;
    @(negedge clk);
    lo_write = 1'b0;
    chk("mtlo lo", 64'(lo), 64'h0BAD_F00D);
    chk("mtlo hi_kept", 64'(hi), 64'hDEAD_BEEF);
    hi_write = 1'b1; lo_write = 1'b1; md = 32'hCAFE_F00D;
    @(negedge clk);
    hi_write = 1'b0; lo_write = 1'b0;
    chk("mthilo hi", 64'(hi), 64'hCAFE_F00D);
    chk("mthilo lo", 64'(lo), 64'hCAFE_F00D);

    // A move coinciding with an accepted Start lands, then the result overwrites it.
    hi_write = 1'b1; md = 32'h5555_AAAA;
    start = 1'b1; op = 2'd1; a = 32'd2; b = 32'd3;
    @(negedge clk);
    hi_write = 1'b0; start = 1'b0;
    chk("mthi_with_start hi", 64'(hi), 64'h5555_AAAA);
    wait_done(lat, bcnt);
    chk("mthi_with_start latency", 64'(lat), 64'(34));
    chk("mthi_with_start hi_result", 64'(hi), 64'h0);
    chk("mthi_with_start lo_result", 64'(lo), 64'd6);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(3));
      ra = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(5))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(9));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, 1'($urandom_range(1)));
    end

    // Asynchronous reset mid-operation abandons it and clears HI/LO immediately.
    @(negedge clk);
    hi_write = 1'b1; lo_write = 1'b1; md = 32'h7777_1111;
    @(negedge clk);
    hi_write = 1'b0; lo_write = 1'b0;
    start = 1'b1; op = 2'd1; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_reset busy", 64'(busy), 64'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_reset busy", 64'(busy), 64'(0));
    chk("async_reset done", 64'(done), 64'(0));
    chk("async_reset hi", 64'(hi), 64'(0));
    chk("async_reset lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("post_reset no_done", 64'(dcnt), 64'(0));
    chk("post_reset lo_held", 64'(lo), 64'(0));
    run_op("after_reset_multu", 2'd1, 32'd2, 32'd2, 1'b0);
    chk("after_reset lo const", 64'(lo), 64'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
Iterative multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the register file: it consumes ReadData1/ReadData2 as OperandA/OperandB for MULT, MULTU, DIV and DIVU. Its Hi/Lo outputs feed the writeback mux for MFHI/MFLO. Sequential shift-add multiply and restoring divide are used, with a fixed latency.

Parameters:
WIDTH, 32, operand and HI/LO width (only 32 is verified)
CNT_W, 5, iteration counter width, log2(WIDTH)

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high; clears all state
Start  input  1  begin an operation; sampled only in IDLE
Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start
OperandA  input  32  rs value (multiplicand / dividend)
OperandB  input  32  rt value (multiplier / divisor)
HiWrite  input  1  MTHI strobe
LoWrite  input  1  MTLO strobe
MoveData  input  32  data for MTHI/MTLO
Busy  output  1  high while an operation is in flight
Done  output  1  one-cycle pulse when Hi/Lo take a new result
DivByZero  output  1  pulses with Done when a DIV/DIVU had OperandB==0
Hi  output  32  HI register
Lo  output  32  LO register

Behaviour:
- Reset (async, active-high, any state): state=IDLE; Busy=0, Done=0, DivByZero=0, Hi=0, Lo=0, counter=0. An operation in flight is abandoned and no partial result is written.
- FSM states: IDLE, PREP, CALC, FIX; all registered.
- IDLE: Start=1 at an edge latches Op, OperandA, OperandB -> PREP. In the same edge, Busy goes 1.
- PREP (1 cycle): for signed ops, take absolute values and record the result signs. Clear the accumulator and counter. -> CALC.
- CALC (32 cycles, counter 0..31): perform one shift-add (mul) or shift-subtract-restore (div) step per cycle. At counter==31 -> FIX.
- FIX (1 cycle): apply sign correction, write Hi/Lo, Done<=1 for one cycle -> IDLE, Busy<=0.
- Latency: Start sampled at edge 0; Hi/Lo/Done update at edge 34; Busy high from edge 0 to edge 34. Back-to-back: Start may be asserted in the cycle Done is high; it is accepted at edge 35.
- Start while Busy=1: ignored; no queueing.
- Multiply: {Hi,Lo} = 64-bit product. MULT uses two's-complement operands; MULTU uses unsigned operands.
- Divide: Lo=quotient, Hi=remainder.
  - Signed quotient truncates toward zero.
  - The remainder takes the dividend's sign.
  - DIV 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0, no flag.
- Divide by zero (DIV or DIVU with OperandB==0): same latency. Hi=OperandA, Lo=0xFFFFFFFF, DivByZero=1 together with Done.
- HiWrite/LoWrite: take effect at the edge only when Busy=0 (IDLE); ignored while Busy=1.
  - If a strobe coincides with an accepted Start, the move is applied, and the later result overwrites it.
  - HiWrite and LoWrite may both be high at once; both then take MoveData.
- Hi/Lo are stable and hold their value between updates. Operand inputs may change freely after Start is accepted.
- Done and DivByZero are never high outside the FIX->IDLE cycle.

Test Plan:
- MULT 0x00000007 x 0xFFFFFFFD -> after 34 edges Done=1 for one cycle, Hi=0xFFFFFFFF, Lo=0xFFFFFFEB; Busy high for exactly 34 cycles.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. Then MULT on the same operands -> Hi=0, Lo=1.
- DIV 0xFFFFFFF9 / 0x00000002 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. DIVU 100/7 -> Lo=14, Hi=2. DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU 0x00000064 / 0 -> Done and DivByZero high together, Hi=0x00000064, Lo=0xFFFFFFFF. The next op's Done has DivByZero=0.
- Start MULT 3x5, re-pulse Start at cycle 10 with DIV, HiWrite at cycle 12 (ignored) -> Hi=0, Lo=15 at edge 34. Then HiWrite MoveData=0xDEADBEEF in IDLE -> Hi=0xDEADBEEF next edge, Lo=15.
- Start MULTU 2x2, assert Reset asynchronously mid-cycle at cycle 20 -> Busy, Done, Hi, Lo all 0 immediately. After release, the bench checks no Done occurs; a new Start 2x2 gives Lo=4 at 34 edges.
